// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage between the PC register and ID.
//
// Issues single-word reads to instruction memory and presents the returned
// word to ID as a registered instr/instr_pc/instr_vld triple. A one-entry skid
// register absorbs a word that returns while ID is stalled. Redirects flush
// the fetch path, and an outstanding read is drained before the next fetch.
// hlt freezes the unit until rst.
//
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_cnt/stall_cnt counters.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   pc_addr       current PC value
//   redirect      branch/jump taken in EX (PC loads target this edge)
//   hlt           halt request
//   stall         ID not accepting; instr/instr_vld hold
//   pc_hold       comb; 0 only when an instruction is accepted (PC += 1)
//   mem_rd_en     instruction memory read request
//   mem_addr      instruction memory read address
//   mem_rdy       read data valid this cycle
//   mem_data      instruction word from memory
//   instr         registered instruction to ID
//   instr_pc      registered address of instr
//   instr_vld     registered valid for instr
//   fetch_cnt     (FETCH_PERF_CNT_EN) count of instr_vld loads
//   stall_cnt     (FETCH_PERF_CNT_EN) count of waiting/skid-full cycles
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_addr,
  input  logic        redirect,
  input  logic        hlt,
  input  logic        stall,
  output logic        pc_hold,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_vld
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, FULL, DRAIN, HALT} state_t;

  state_t      state;
  logic [15:0] req_addr;
  logic [15:0] skid_instr;
  logic [15:0] skid_pc;
  logic        halt_pend;

  logic accept;   // word returned in REQ and not killed by hlt/redirect
  logic to_skid;  // accepted word must park in the skid register
  logic ld_mem;   // accepted word goes straight to ID
  logic ld_skid;  // skid word moves to ID

  always_comb begin
    accept  = (state == REQ) && mem_rdy && !hlt && !redirect;
    to_skid = accept && instr_vld && stall;
    ld_mem  = accept && !to_skid;
    ld_skid = (state == FULL) && !hlt && !redirect && !stall;
  end

  always_comb begin
    pc_hold   = 1'b1;
    mem_rd_en = 1'b0;
    mem_addr  = req_addr;
    case (state)
      REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = pc_addr;
        pc_hold   = !accept;
      end
      DRAIN: begin
        // Read protocol requires the address to stay put until mem_rdy,
        // even though the PC has already moved to the redirect target.
        mem_rd_en = 1'b1;
        mem_addr  = req_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      instr      <= '0;
      instr_pc   <= '0;
      instr_vld  <= 1'b0;
      req_addr   <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      halt_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= hlt ? HALT : REQ;

        REQ: begin
          req_addr <= pc_addr;
          if (hlt) begin
            instr_vld <= 1'b0;
            if (mem_rdy) begin
              state <= HALT;
            end else begin
              halt_pend <= 1'b1;
              state     <= DRAIN;
            end
          end else if (redirect) begin
            instr_vld <= 1'b0;
            if (!mem_rdy) state <= DRAIN;
          end else if (ld_mem) begin
            instr     <= mem_data;
            instr_pc  <= pc_addr;
            instr_vld <= 1'b1;
          end else if (to_skid) begin
            skid_instr <= mem_data;
            skid_pc    <= pc_addr;
            state      <= FULL;
          end else if (!stall) begin
            instr_vld <= 1'b0;
          end
        end

        FULL: begin
          if (hlt || redirect) begin
            instr_vld  <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            state      <= hlt ? HALT : REQ;
          end else if (ld_skid) begin
            instr     <= skid_instr;
            instr_pc  <= skid_pc;
            instr_vld <= 1'b1;
            state     <= REQ;
          end
        end

        DRAIN: begin
          instr_vld <= 1'b0;
          if (hlt) halt_pend <= 1'b1;
          if (mem_rdy) state <= (halt_pend || hlt) ? HALT : REQ;
        end

        HALT: instr_vld <= 1'b0;

        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (ld_mem || ld_skid) fetch_cnt <= fetch_cnt + 16'd1;
      if ((((state == REQ) || (state == DRAIN)) && !mem_rdy) || (state == FULL))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 pc_addr  in  16  current PC address from PC register.
REQ-004 redirect  in  1  branch or jump taken in EX; PC loads target at this edge regardless of hold.
REQ-005 hlt  in  1  halt; PC freezes.
REQ-006 stall  in  1  ID stage not accepting; instr/instr_vld must hold.
REQ-007 pc_hold  out  1  combinational; 0 only in the cycle an instruction is accepted, so PC advances by one.
REQ-008 mem_rd_en  out  1  instruction memory read request.
REQ-009 mem_addr  out  16  read address.
REQ-010 mem_rdy  in  1  memory data valid this cycle, completes request.
REQ-011 mem_data  in  16  instruction word.
REQ-012 instr  out  16  registered instruction to ID.
REQ-013 instr_pc  out  16  registered address of instr.
REQ-014 instr_vld  out  1  registered; instr valid.

Function
REQ-015 States SHALL be IDLE, REQ, FULL, DRAIN, HALT; req_addr SHALL be a 16-bit register holding the outstanding address.
REQ-016 IDLE: mem_rd_en=0, pc_hold=1; next state REQ unconditionally (hlt: HALT).
REQ-017 REQ: mem_rd_en=1, mem_addr=pc_addr, req_addr<=pc_addr each cycle; address stays stable because pc_hold=1 until acceptance.
REQ-018 REQ, mem_rdy=1, slot free (instr_vld=0 or stall=0): instr<=mem_data, instr_pc<=pc_addr, instr_vld<=1, pc_hold=0, stay REQ; sustained throughput SHALL be 1 instruction/cycle with zero-wait memory.
REQ-019 REQ, mem_rdy=1, slot full (instr_vld=1 and stall=1): mem_data and pc_addr SHALL be captured in a one-entry skid register; pc_hold=0; go FULL.
REQ-020 REQ, mem_rdy=0: instr_vld<=0 if stall=0, else hold; pc_hold=1.
REQ-021 FULL: mem_rd_en=0, pc_hold=1; when stall=0, instr/instr_pc<=skid, instr_vld<=1, go REQ.
REQ-022 Redirect in REQ with mem_rdy=1: data discarded, instr_vld<=0, pc_hold don't-care (PC loads target), stay REQ.
REQ-023 Redirect in REQ with mem_rdy=0: instr_vld<=0, go DRAIN.
REQ-024 DRAIN: mem_rd_en=1, mem_addr=req_addr (protocol: address stable until mem_rdy); on mem_rdy data discarded, go REQ (HALT if halt pending); further redirects stay DRAIN.
REQ-025 Redirect in FULL: skid and instr_vld cleared, go REQ.
REQ-026 Redirect overrides stall for flushing instr_vld.
REQ-027 hlt in REQ with mem_rdy=0: set halt pending, go DRAIN; otherwise go HALT directly, discarding any mem_data that cycle.
REQ-028 HALT: mem_rd_en=0, pc_hold=1, instr_vld=0; exit only via rst.
REQ-029 hlt has priority over redirect; redirect over mem_rdy acceptance.
REQ-030 mem_rdy outside REQ/DRAIN SHALL be ignored.

Reset
REQ-031 rst=1 at posedge: state<=IDLE, instr<=16'h0000, instr_pc<=16'h0000, instr_vld<=0, req_addr<=0, skid empty, halt pending cleared, counters cleared.
REQ-032 rst mid-request SHALL abandon the request; mem_rd_en=0 the cycle after reset.

Configuration
REQ-033 Macro FETCH_PERF_CNT_EN: when defined, adds outputs fetch_cnt[15:0] (increments on each instr_vld load) and stall_cnt[15:0] (increments each cycle state is REQ/DRAIN with mem_rdy=0, or FULL); both wrap 16'hFFFF->0, cleared by rst.
REQ-034 Without FETCH_PERF_CNT_EN those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-035 Reset, mem_rdy tied 1, pc stepping 0,1,2 -> instr_vld=1 from cycle 2, instr_pc 0,1,2 consecutive, pc_hold=0 every cycle.
REQ-036 mem_rdy after 3 wait cycles at pc_addr=16'h0010 -> mem_rd_en/mem_addr stable 3 cycles, pc_hold=1 then 0 once, instr_pc=16'h0010.
REQ-037 stall=1 with instr_vld=1, mem_rdy=1 -> state FULL, instr unchanged; stall=0 -> skid word appears next cycle, PC advanced exactly once.
REQ-038 redirect while waiting on req_addr=16'h0020 -> DRAIN keeps mem_addr=16'h0020 until mem_rdy, data discarded, next fetch at target, instr_vld=0 meanwhile.
REQ-039 hlt while waiting -> drain then HALT, mem_rd_en=0, instr_vld=0 until rst=1.
REQ-040 With FETCH_PERF_CNT_EN, 5 fetches and 3 wait cycles -> fetch_cnt=5, stall_cnt=3.
